multi_solver_frame_buffer: RTL

//   Parametrised, double-buffered collector for NUM_SOLVERS interleaved fractal solvers.

---
 rtl/multi_solver_frame_buffer_if.sv | 31 +++
 rtl/multi_solver_frame_buffer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/multi_solver_frame_buffer_if.sv
// Solver stream and pixel read bus for the frame buffer.
// slave: buffer side (solver inputs, read port); master: solvers/readout.
interface multi_solver_frame_buffer_if #(
  parameter int NUM_SOLVERS = 4,
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 19
);
  logic                          sol_reset;
  logic [NUM_SOLVERS-1:0]        sol_continue;
  logic [NUM_SOLVERS-1:0]        sol_valid;
  logic [NUM_SOLVERS*DATA_W-1:0] sol_data;
  logic [NUM_SOLVERS-1:0]        sol_done;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic [DATA_W-1:0]             rd_data;
  logic                          rd_valid;

  modport slave (
    input  sol_valid, sol_data, sol_done,
    input  rd_en, rd_addr,
    output sol_reset, sol_continue,
    output rd_data, rd_valid
  );

  modport master (
    output sol_valid, sol_data, sol_done,
    output rd_en, rd_addr,
    input  sol_reset, sol_continue,
    input  rd_data, rd_valid
  );
endinterface

// File: rtl/multi_solver_frame_buffer.sv
// Double-buffered collector for interleaved solvers; linear-index reads.
// Ports: clock/reset, start/abort, status (busy, frame_ready, frame_count, overflow), bus.
module multi_solver_frame_buffer #(
  parameter int NUM_SOLVERS = 4,
  parameter int DATA_W      = 4,
  parameter int PIXELS      = 307200,
  parameter int ADDR_W      = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       frame_ready,
  output logic [7:0] frame_count,
  output logic       overflow,
  multi_solver_frame_buffer_if.slave bus
);
  localparam int DEPTH = PIXELS / NUM_SOLVERS;
  localparam int SEL_W = $clog2(NUM_SOLVERS);
  localparam int SW    = (SEL_W > 0) ? SEL_W : 1;
  localparam int LA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PDEPTH = ptr_t'(DEPTH);
  localparam logic [ADDR_W:0] PIX_L = (ADDR_W+1)'(PIXELS);

  typedef enum logic [1:0] {
    IDLE, CLEAR, RUN, SWAP
  } state_t;

  state_t state;
  logic   front;
  ptr_t   wr_ptr [NUM_SOLVERS];

  logic [DATA_W-1:0] mem [2][NUM_SOLVERS][DEPTH];

  logic [NUM_SOLVERS-1:0] full;
  logic [NUM_SOLVERS-1:0] cont;
  logic [NUM_SOLVERS-1:0] wen;

  always_comb begin
    full = '0;
    cont = '0;
    wen  = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      full[i] = (wr_ptr[i] == PDEPTH);
      cont[i] = (state == RUN) && !full[i];
      wen[i]  = bus.sol_valid[i] && cont[i];
    end
  end

  assign bus.sol_continue = cont;
  assign bus.sol_reset    = reset || (state == CLEAR);
  assign busy             = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      front       <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= 8'd0;
      overflow    <= 1'b0;
      for (int i = 0; i < NUM_SOLVERS; i++)
        wr_ptr[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= CLEAR;
            overflow <= 1'b0;
          end
        end
        CLEAR: begin
          for (int i = 0; i < NUM_SOLVERS; i++)
            wr_ptr[i] <= '0;
          state <= abort ? IDLE : RUN;
        end
        RUN: begin
          for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (wen[i])
              wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (bus.sol_valid[i] && full[i])
              overflow <= 1'b1;
          end
          if (abort)
            state <= IDLE;
          else if (&bus.sol_done && &full)
            state <= SWAP;
        end
        SWAP: begin
          front       <= ~front;
          frame_ready <= 1'b1;
          frame_count <= frame_count + 8'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes always land in the back bank, so reads of the
  // front bank never collide with a solver write.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (wen[i])
        mem[!front][i][wr_ptr[i][LA_W-1:0]] <=
          bus.sol_data[i*DATA_W +: DATA_W];
    end
  end

  logic [SW-1:0]     sel;
  logic [ADDR_W-1:0] la_full;
  logic [LA_W-1:0]   la;
  logic              in_range;

  assign sel      = (SEL_W > 0) ? bus.rd_addr[SW-1:0] : '0;
  assign la_full  = bus.rd_addr >> SEL_W;
  assign la       = la_full[LA_W-1:0];
  assign in_range = ({1'b0, bus.rd_addr} < PIX_L);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en)
        bus.rd_data <= (frame_ready && in_range) ?
                       mem[front][sel][la] : '0;
    end
  end
endmodule
